// File: rtl/register_bank_ctx.sv
// rtl/register_bank_ctx.sv - register bank with shared write port, two read ports, PC update and context save/restore streams
module register_bank_ctx #(
    parameter int DATA_W  = 16,
    parameter int NUM_GPR = 8,
    parameter int ADDR_W  = 14,
    parameter int PC_STEP = 1,
    parameter int SEL_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              trnsfr,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  sel_ip,
    input  logic [SEL_W-1:0]  sel_op,
    input  logic [SEL_W-1:0]  sel_b,
    output logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] dout_b,
    input  logic [DATA_W-1:0] alu_in,
    input  logic              alu_en,
    input  logic              pc_rst,
    input  logic              pc_hold,
    input  logic              pc_rel,
    input  logic              pc_inc,
    output logic [DATA_W-1:0] pc_op,
    output logic [DATA_W-1:0] ir_op,
    output logic [DATA_W-1:0] d1_op,
    output logic [DATA_W-1:0] d2_op,
    output logic [ADDR_W-1:0] addr,
    input  logic              ctx_save,
    input  logic              ctx_restore,
    output logic              ctx_busy,
    output logic              ctx_done,
    output logic [DATA_W-1:0] ctx_out_data,
    output logic              ctx_out_valid,
    input  logic              ctx_out_ready,
    input  logic [DATA_W-1:0] ctx_in_data,
    input  logic              ctx_in_valid,
    output logic              ctx_in_ready
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SAVE    = 2'd1;
    localparam logic [1:0] ST_RESTORE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]        state;
    logic [4:0]        k;
    logic [DATA_W-1:0] pc, ar, alu_reg, ir, d1, d2;
    logic [DATA_W-1:0] gpr [NUM_GPR];

    logic              idle;
    logic              idle_wr;
    logic              save_beat;
    logic              restore_beat;
    logic              last_beat;
    logic [DATA_W-1:0] wdata;

    assign idle          = (state == ST_IDLE);
    assign idle_wr       = idle && wr_en;
    assign save_beat     = (state == ST_SAVE) && ctx_out_ready;
    assign restore_beat  = (state == ST_RESTORE) && ctx_in_valid;
    assign last_beat     = (k == 5'(NUM_GPR));
    assign wdata         = trnsfr ? din : dout;

    assign ctx_busy      = !idle;
    assign ctx_done      = (state == ST_DONE);
    assign ctx_out_valid = (state == ST_SAVE);
    assign ctx_in_ready  = (state == ST_RESTORE);

    assign pc_op = pc;
    assign ir_op = ir;
    assign d1_op = d1;
    assign d2_op = d2;
    assign addr  = ar[ADDR_W-1:0];

    // Read port A: unmapped indices read as zero
    always_comb begin
        dout = '0;
        case (sel_op)
            SEL_W'(0): dout = pc;
            SEL_W'(1): dout = ar;
            SEL_W'(2): dout = alu_reg;
            SEL_W'(3): dout = ir;
            SEL_W'(4): dout = d1;
            SEL_W'(5): dout = d2;
            default:   dout = '0;
        endcase
        for (int i = 0; i < NUM_GPR; i++) begin
            if (sel_op == SEL_W'(6 + i)) dout = gpr[i];
        end
    end

    // Read port B: same map as port A
    always_comb begin
        dout_b = '0;
        case (sel_b)
            SEL_W'(0): dout_b = pc;
            SEL_W'(1): dout_b = ar;
            SEL_W'(2): dout_b = alu_reg;
            SEL_W'(3): dout_b = ir;
            SEL_W'(4): dout_b = d1;
            SEL_W'(5): dout_b = d2;
            default:   dout_b = '0;
        endcase
        for (int i = 0; i < NUM_GPR; i++) begin
            if (sel_b == SEL_W'(6 + i)) dout_b = gpr[i];
        end
    end

    // Save stream data: beat 0 is PC, beat k is GPR(k-1); purely a function of k so it holds while stalled
    always_comb begin
        ctx_out_data = pc;
        for (int i = 0; i < NUM_GPR; i++) begin
            if (k == 5'(i + 1)) ctx_out_data = gpr[i];
        end
    end

    // Context engine: new requests only accepted in IDLE, save wins over restore
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            k     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    k <= '0;
                    if (ctx_save)         state <= ST_SAVE;
                    else if (ctx_restore) state <= ST_RESTORE;
                end
                ST_SAVE: begin
                    if (save_beat) begin
                        k <= k + 5'd1;
                        if (last_beat) state <= ST_DONE;
                    end
                end
                ST_RESTORE: begin
                    if (restore_beat) begin
                        k <= k + 5'd1;
                        if (last_beat) state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // PC: restore beat 0 first, then clear/hold, then the IDLE-only update sources
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= '0;
        end else if (restore_beat && (k == 5'd0)) begin
            pc <= ctx_in_data;
        end else if (pc_rst) begin
            pc <= '0;
        end else if (pc_hold) begin
            pc <= pc;
        end else if (idle) begin
            if (pc_rel)                            pc <= pc + din;
            else if (pc_inc)                       pc <= pc + DATA_W'(PC_STEP);
            else if (wr_en && sel_ip == SEL_W'(0)) pc <= wdata;
        end
    end

    // ALUREG only ever takes the ALU result; alu_en works in every state
    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_reg <= '0;
        end else if (alu_en || (idle_wr && sel_ip == SEL_W'(2))) begin
            alu_reg <= alu_in;
        end
    end

    // Special registers written only through the shared port in IDLE
    always_ff @(posedge clk) begin
        if (!rst) begin
            ar <= '0;
            ir <= '0;
            d1 <= '0;
            d2 <= '0;
        end else if (idle_wr) begin
            if (sel_ip == SEL_W'(1)) ar <= wdata;
            if (sel_ip == SEL_W'(3)) ir <= wdata;
            if (sel_ip == SEL_W'(4)) d1 <= wdata;
            if (sel_ip == SEL_W'(5)) d2 <= wdata;
        end
    end

    // GPRs: shared write port in IDLE, restore stream beats 1..NUM_GPR
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_GPR; i++) begin
            if (!rst) begin
                gpr[i] <= '0;
            end else if (idle_wr && sel_ip == SEL_W'(6 + i)) begin
                gpr[i] <= wdata;
            end else if (restore_beat && k == 5'(i + 1)) begin
                gpr[i] <= ctx_in_data;
            end
        end
    end

endmodule

// File: tb/tb_register_bank_ctx.sv
// tb/tb_register_bank_ctx.sv - scoreboard bench for register_bank_ctx
module tb_register_bank_ctx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        trnsfr;
    logic        wr_en;
    logic [3:0]  sel_ip, sel_op, sel_b;
    logic [15:0] dout, dout_b;
    logic [15:0] alu_in;
    logic        alu_en;
    logic        pc_rst, pc_hold, pc_rel, pc_inc;
    logic [15:0] pc_op, ir_op, d1_op, d2_op;
    logic [13:0] addr;
    logic        ctx_save, ctx_restore, ctx_busy, ctx_done;
    logic [15:0] ctx_out_data;
    logic        ctx_out_valid, ctx_out_ready;
    logic [15:0] ctx_in_data;
    logic        ctx_in_valid, ctx_in_ready;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] rvals[9];

    register_bank_ctx dut (
        .clk(clk), .rst(rst), .din(din), .trnsfr(trnsfr), .wr_en(wr_en),
        .sel_ip(sel_ip), .sel_op(sel_op), .sel_b(sel_b), .dout(dout), .dout_b(dout_b),
        .alu_in(alu_in), .alu_en(alu_en), .pc_rst(pc_rst), .pc_hold(pc_hold),
        .pc_rel(pc_rel), .pc_inc(pc_inc), .pc_op(pc_op), .ir_op(ir_op),
        .d1_op(d1_op), .d2_op(d2_op), .addr(addr), .ctx_save(ctx_save),
        .ctx_restore(ctx_restore), .ctx_busy(ctx_busy), .ctx_done(ctx_done),
        .ctx_out_data(ctx_out_data), .ctx_out_valid(ctx_out_valid),
        .ctx_out_ready(ctx_out_ready), .ctx_in_data(ctx_in_data),
        .ctx_in_valid(ctx_in_valid), .ctx_in_ready(ctx_in_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] sel, input logic [15:0] data);
        sel_ip = sel; din = data; trnsfr = 1'b1; wr_en = 1'b1;
        tick();
        wr_en = 1'b0; trnsfr = 1'b0;
    endtask

    // Monitor: pops the expected save beat on every accepted beat and checks stall stability
    initial begin
        logic        prev_v;
        logic        prev_r;
        logic [15:0] prev_d;
        prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
        forever begin
            @(negedge clk);
            if (ctx_done === 1'b1) done_cnt++;
            if (prev_v && !prev_r && ctx_out_valid) check("save_hold", ctx_out_data, prev_d);
            if (ctx_out_valid && ctx_out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL save_extra_beat: got %h expected no beat", ctx_out_data);
                end else begin
                    check("save_beat", ctx_out_data, exp_q.pop_front());
                end
            end
            prev_v = ctx_out_valid; prev_r = ctx_out_ready; prev_d = ctx_out_data;
        end
    end

    initial begin
        int cyc;
        int i;
        logic hs;
        rst = 1'b0; din = '0; trnsfr = 1'b0; wr_en = 1'b0;
        sel_ip = '0; sel_op = '0; sel_b = '0; alu_in = '0; alu_en = 1'b0;
        pc_rst = 1'b0; pc_hold = 1'b0; pc_rel = 1'b0; pc_inc = 1'b0;
        ctx_save = 1'b0; ctx_restore = 1'b0; ctx_out_ready = 1'b0;
        ctx_in_data = '0; ctx_in_valid = 1'b0;
        for (int n = 0; n < 9; n++) rvals[n] = (n == 0) ? 16'h0200 : 16'(16'h0010 + n);

        tick(); tick();
        check("rst_pc", pc_op, 16'h0000);
        check("rst_addr", 16'(addr), 16'h0000);
        check("rst_busy", 16'(ctx_busy), 16'h0000);
        check("rst_out_valid", 16'(ctx_out_valid), 16'h0000);
        check("rst_in_ready", 16'(ctx_in_ready), 16'h0000);
        check("rst_done", 16'(ctx_done), 16'h0000);
        rst = 1'b1;

        // write and move
        wr(4'd9, 16'hA5A5);
        sel_op = 4'd9; #1;
        check("gpr3_write", dout, 16'hA5A5);
        sel_ip = 4'd4; trnsfr = 1'b0; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        check("move_d1", d1_op, 16'hA5A5);
        sel_b = 4'd4; #1;
        check("port_b_d1", dout_b, 16'hA5A5);

        // PC paths
        wr(4'd0, 16'hFFFF);
        check("pc_write", pc_op, 16'hFFFF);
        pc_inc = 1'b1; tick(); pc_inc = 1'b0;
        check("pc_inc_wrap", pc_op, 16'h0000);
        pc_rel = 1'b1; din = 16'h0010; tick(); pc_rel = 1'b0;
        check("pc_rel", pc_op, 16'h0010);
        wr(4'd0, 16'h1234);
        pc_hold = 1'b1; pc_inc = 1'b1; tick();
        check("pc_hold_over_inc", pc_op, 16'h1234);
        pc_rst = 1'b1; tick();
        pc_rst = 1'b0; pc_hold = 1'b0; pc_inc = 1'b0;
        check("pc_rst_priority", pc_op, 16'h0000);

        // AR, ALUREG, out-of-range index
        wr(4'd1, 16'hFFFF);
        check("addr_lsbs", 16'(addr), 16'h3FFF);
        alu_in = 16'h0077;
        wr(4'd2, 16'h5555);
        sel_op = 4'd2; #1;
        check("alureg_from_alu", dout, 16'h0077);
        wr(4'd15, 16'hDEAD);
        sel_op = 4'd15; #1;
        check("read_idx15", dout, 16'h0000);
        sel_op = 4'd14; #1;
        check("read_idx14", dout, 16'h0000);
        check("idx15_no_d1", d1_op, 16'hA5A5);
        check("idx15_no_pc", pc_op, 16'h0000);

        // save with ready toggling
        for (int n = 0; n < 8; n++) wr(4'(6 + n), 16'(n + 1));
        wr(4'd0, 16'h0100);
        exp_q.push_back(16'h0100);
        for (int n = 1; n <= 8; n++) exp_q.push_back(16'(n));
        ctx_out_ready = 1'b1;
        ctx_save = 1'b1; tick(); ctx_save = 1'b0;
        cyc = 0;
        while (!ctx_done && cyc < 100) begin
            if (cyc == 2) begin
                sel_ip = 4'd6; din = 16'hFFFF; trnsfr = 1'b1; wr_en = 1'b1;
            end else begin
                wr_en = 1'b0; trnsfr = 1'b0;
            end
            tick();
            cyc++;
            ctx_out_ready = ~ctx_out_ready;
        end
        wr_en = 1'b0; trnsfr = 1'b0; ctx_out_ready = 1'b0;
        check("save_done_seen", 16'(ctx_done), 16'h0001);
        ctx_save = 1'b1; tick(); ctx_save = 1'b0;
        check("save_in_done_ignored", 16'(ctx_busy), 16'h0000);
        check("save_beats_left", 16'(exp_q.size()), 16'h0000);
        check("save_done_pulses", 16'(done_cnt), 16'h0001);
        sel_op = 4'd6; #1;
        check("save_wr_ignored", dout, 16'h0001);

        // restore with valid gaps and alu_en mid-stream
        ctx_restore = 1'b1; tick(); ctx_restore = 1'b0;
        i = 0; cyc = 0;
        while (i < 9 && cyc < 100) begin
            ctx_in_valid = (cyc % 3 != 1);
            ctx_in_data  = rvals[i];
            alu_en = (cyc == 4); alu_in = 16'hBEEF;
            hs = ctx_in_valid && ctx_in_ready;
            tick();
            cyc++;
            if (hs) i++;
        end
        ctx_in_valid = 1'b0; alu_en = 1'b0;
        check("restore_beats", 16'(i), 16'h0009);
        check("restore_done", 16'(ctx_done), 16'h0001);
        tick();
        check("restore_idle", 16'(ctx_busy), 16'h0000);
        check("restore_pc", pc_op, 16'h0200);
        for (int n = 0; n < 8; n++) begin
            sel_op = 4'(6 + n); #1;
            check("restore_gpr", dout, 16'(16'h0011 + n));
        end
        sel_op = 4'd2; #1;
        check("restore_alureg", dout, 16'hBEEF);
        check("restore_done_pulses", 16'(done_cnt), 16'h0002);

        // reset in the middle of a save
        exp_q.push_back(16'h0200);
        exp_q.push_back(16'h0011);
        exp_q.push_back(16'h0012);
        exp_q.push_back(16'h0013);
        ctx_save = 1'b1; tick(); ctx_save = 1'b0;
        ctx_out_ready = 1'b1;
        for (int n = 0; n < 4; n++) tick();
        ctx_out_ready = 1'b0;
        rst = 1'b0; tick(); rst = 1'b1;
        check("midrst_busy", 16'(ctx_busy), 16'h0000);
        check("midrst_valid", 16'(ctx_out_valid), 16'h0000);
        check("midrst_beats_left", 16'(exp_q.size()), 16'h0000);
        for (int n = 0; n < 14; n++) begin
            sel_op = 4'(n); #1;
            check("midrst_reg_zero", dout, 16'h0000);
        end
        tick(); tick();
        check("midrst_no_done", 16'(done_cnt), 16'h0002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
